// File: rtl/univ_reg.sv
// -----------------------------------------------------------------------------
// univ_reg : parametrised universal register
//
// This is a WIDTH-bit state element that supports parallel load, serial shift,
// rotate and increment/decrement. It also provides a registered carry or
// shifted-out bit, a complementary output and a zero flag. It serves as the
// accumulator, shift unit and program counter element of the datapath.
//
// Parameters
//   WIDTH     : register width in bits (>= 2)
//   RESET_VAL : value forced onto q while r is high
//
// Ports
//   clk  in  1      rising-edge clock
//   r    in  1      asynchronous active-high reset
//   en   in  1      clock enable; 0 holds q and co
//   mode in  3      operation select (see mode_t)
//   d    in  WIDTH  parallel load data
//   sin  in  1      serial input for the shift modes
//   q    out WIDTH  register contents
//   qbar out WIDTH  bitwise complement of q
//   co   out 1      registered carry / borrow / shifted-out bit
//   zero out 1      1 iff q == 0 (combinational)
// -----------------------------------------------------------------------------
module univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_t;

  logic [WIDTH-1:0] r_q;
  logic             r_co;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_co_nxt;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;

  // The increment is computed one bit wider so that the carry out of the
  // all-ones wrap falls directly into the top bit.
  assign w_inc = {1'b0, r_q} + (WIDTH+1)'(1);
  assign w_dec = r_q - WIDTH'(1);

  // Every mode reads only the pre-edge r_q, so each result is independent
  // of the order in which the mode decode runs.
  always_comb begin
    // NOTE: defaults first -- every path assigns both outputs, so no latch is inferred.
    w_q_nxt  = r_q;
    w_co_nxt = r_co;
    if (en) begin
      unique case (mode_t'(mode))
        MODE_HOLD: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
        MODE_LOAD: begin
          w_q_nxt  = d;
          w_co_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], sin};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_nxt  = {sin, r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
        MODE_ROL: begin
          w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_co_nxt = r_q[WIDTH-1];
        end
        MODE_ROR: begin
          w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
          w_co_nxt = r_q[0];
        end
        MODE_INC: begin
          w_q_nxt  = w_inc[WIDTH-1:0];
          w_co_nxt = w_inc[WIDTH];
        end
        MODE_DEC: begin
          // A borrow occurs only when decrementing from zero.
          w_q_nxt  = w_dec;
          w_co_nxt = (r_q == '0);
        end
        default: begin
          w_q_nxt  = r_q;
          w_co_nxt = r_co;
        end
      endcase
    end
  end

  // Reset dominates any coincident edge and every edge while r stays high.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_q  <= RESET_VAL;
      r_co <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      r_q  <= w_q_nxt;
      r_co <= w_co_nxt;
    end
  end

  // qbar and zero have no register stage and always follow q.
  assign q    = r_q;
  assign qbar = ~r_q;
  assign co   = r_co;
  assign zero = (r_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_reg : self-checking bench for univ_reg (WIDTH = 8, RESET_VAL = A5)
//
// An arithmetic reference model, using integer multiply, divide and modulo,
// tracks q and co. A compare process checks all four outputs against the
// model on every falling edge. Directed steps also check hand-computed
// literal values at points of interest.
// -----------------------------------------------------------------------------
module tb_univ_reg;

  localparam int         W   = 8;
  localparam int         MOD = 1 << W;
  localparam logic [7:0] RV  = 8'hA5;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  logic         clk;
  logic         r;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         co;
  logic         zero;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // Reference model state.
  int m_q  = 0;
  int m_co = 0;

  univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk  (clk),
    .r    (r),
    .en   (en),
    .mode (mode),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .qbar (qbar),
    .co   (co),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model computes each update from the register value treated as an
  // unsigned integer.
  always @(posedge clk or posedge r) begin
    int nq;
    int nco;
    if (r) begin
      m_q  = int'(RV);
      m_co = 0;
    end else if (en) begin
      nq  = m_q;
      nco = m_co;
      case (mode)
        M_LOAD: begin nq = int'(d); nco = 0; end
        M_SHL:  begin nco = (m_q >= MOD/2); nq = (m_q * 2 + int'(sin)) % MOD; end
        M_SHR:  begin nco = m_q % 2; nq = m_q / 2 + int'(sin) * (MOD/2); end
        M_ROL:  begin nco = (m_q >= MOD/2); nq = (m_q * 2) % MOD + nco; end
        M_ROR:  begin nco = m_q % 2; nq = m_q / 2 + nco * (MOD/2); end
        M_INC:  begin nq = (m_q + 1) % MOD; nco = (m_q + 1 == MOD); end
        M_DEC:  begin nq = (m_q + MOD - 1) % MOD; nco = (m_q == 0); end
        default: ;
      endcase
      m_q  = nq;
      m_co = nco;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cmp_q",    int'(q),    m_q);
      check("cmp_qbar", int'(qbar), (MOD - 1) - m_q);
      check("cmp_co",   int'(co),   m_co);
      check("cmp_zero", int'(zero), int'(m_q == 0));
    end
  end

  // Apply one set of inputs across a single rising edge, then settle 1ns past it.
  task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] dv,
                      input logic s);
    en   = e;
    mode = m;
    d    = dv;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    r    = 1'b0;
    en   = 1'b0;
    mode = M_HOLD;
    d    = '0;
    sin  = 1'b0;

    // Reset takes effect without a clock edge, and edges are ignored while r is high.
    #2 r = 1'b1;
    #1;
    armed = 1;
    check("rst_q",    int'(q),    8'hA5);
    check("rst_qbar", int'(qbar), 8'h5A);
    check("rst_co",   int'(co),   0);
    check("rst_zero", int'(zero), 0);
    step(1'b1, M_LOAD, 8'hFF, 1'b0);
    step(1'b1, M_INC,  8'h00, 1'b0);
    check("rst_ign_q", int'(q), 8'hA5);
    r = 1'b0;
    step(1'b1, M_LOAD, 8'h3C, 1'b0);
    check("post_rst_load", int'(q), 8'h3C);

    // Load, then verify that en = 0 gates the shift.
    step(1'b1, M_LOAD, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, M_SHL, 8'h00, 1'b1);
    check("en_hold_q",  int'(q),  8'h81);
    check("en_hold_co", int'(co), 0);
    step(1'b1, M_SHL, 8'h00, 1'b1);
    check("shl_q",  int'(q),  8'h03);
    check("shl_co", int'(co), 1);

    // Hold mode keeps q and co.
    step(1'b1, M_HOLD, 8'h55, 1'b1);
    check("hold_q",  int'(q),  8'h03);
    check("hold_co", int'(co), 1);

    // Shift and rotate.
    step(1'b1, M_LOAD, 8'h96, 1'b0);
    step(1'b1, M_SHR,  8'h00, 1'b0);
    check("shr_q",  int'(q),  8'h4B);
    check("shr_co", int'(co), 0);
    step(1'b1, M_ROR, 8'h00, 1'b0);
    check("ror_q",  int'(q),  8'hA5);
    check("ror_co", int'(co), 1);
    step(1'b1, M_ROL, 8'h00, 1'b0);
    check("rol_q",  int'(q),  8'h4B);
    check("rol_co", int'(co), 1);
    step(1'b1, M_SHR, 8'h00, 1'b1);
    check("shr_sin_q",  int'(q),  8'hA5);
    check("shr_sin_co", int'(co), 1);

    // Increment wrap.
    step(1'b1, M_LOAD, 8'hFE, 1'b0);
    step(1'b1, M_INC,  8'h00, 1'b0);
    check("inc1_q",  int'(q),  8'hFF);
    check("inc1_co", int'(co), 0);
    step(1'b1, M_INC, 8'h00, 1'b0);
    check("inc2_q",    int'(q),    8'h00);
    check("inc2_co",   int'(co),   1);
    check("inc2_zero", int'(zero), 1);

    // Decrement borrow.
    step(1'b1, M_LOAD, 8'h01, 1'b0);
    step(1'b1, M_DEC,  8'h00, 1'b0);
    check("dec1_q",    int'(q),    8'h00);
    check("dec1_co",   int'(co),   0);
    check("dec1_zero", int'(zero), 1);
    step(1'b1, M_DEC, 8'h00, 1'b0);
    check("dec2_q",    int'(q),    8'hFF);
    check("dec2_co",   int'(co),   1);
    check("dec2_qbar", int'(qbar), 8'h00);

    // Assert reset asynchronously in the middle of an increment train.
    step(1'b1, M_LOAD, 8'h10, 1'b0);
    step(1'b1, M_INC,  8'h00, 1'b0);
    step(1'b1, M_INC,  8'h00, 1'b0);
    check("train_q", int'(q), 8'h12);
    #1 r = 1'b1;
    #1;
    check("mid_rst_q",  int'(q),  8'hA5);
    check("mid_rst_co", int'(co), 0);
    #1 r = 1'b0;
    step(1'b1, M_INC, 8'h00, 1'b0);
    check("rst_inc_q",  int'(q),  8'hA6);
    check("rst_inc_co", int'(co), 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
